// File: rtl/pattern_stream_generator.sv
// rtl/pattern_stream_generator.sv - serial stimulus stream generator with golden pattern counter
//
// Purpose:
//   Takes a 16-bit stimulus word from a parallel load port and shifts it out
//   MSB-first, one bit every TICK_DIV clock cycles. Each new bit comes with a
//   one-cycle bit_valid strobe. This output feeds the pattern detector's serial
//   input.
//   Alongside the stream, the block keeps a golden count of non-overlapping
//   occurrences of PATTERN. The detector's own count can be compared against it live.
//
// Parameters:
//   TICK_DIV       clock cycles per emitted bit (>= 2)
//   PATTERN        4-bit target pattern, MSB = oldest bit
//
// Ports:
//   clock_100Mhz   in   single rising-edge clock
//   reset          in   asynchronous, active-low reset
//   load           in   capture load_data (IDLE/DONE only)
//   load_data      in   16-bit stimulus word, bit 15 sent first
//   start          in   begin streaming (IDLE/DONE only, load has priority)
//   repeat_en      in   sampled with start; 1 = wrap bit 0 -> bit 15 forever
//   abort          in   leave RUN for IDLE, suppressing any strobe that cycle
//   bit_out        out  current stream bit, held between strobes
//   bit_valid      out  one-cycle strobe marking a new bit_out
//   busy           out  high while streaming
//   done           out  high after a single pass has completed
//   bit_index      out  index of the next bit to send (0 = word bit 15)
//   expected_count out  golden non-overlapping match count, saturating at 255

module pattern_stream_generator #(
    parameter int          TICK_DIV = 100000000,
    parameter logic [3:0]  PATTERN  = 4'b1011
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        start,
    input  logic        repeat_en,
    input  logic        abort,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  bit_index,
    output logic [7:0]  expected_count
);

    localparam int             CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [15:0]    r_word;
    logic [CW-1:0]  r_tick;
    logic [3:0]     r_window;
    logic [2:0]     r_since_match;
    logic           r_repeat;
    logic           r_bit_out;
    logic           r_bit_valid;
    logic           r_busy;
    logic           r_done;
    logic [3:0]     r_bit_index;
    logic [7:0]     r_count;

    logic           w_tick_end;
    logic           w_next_bit;
    logic [3:0]     w_window_next;
    logic [2:0]     w_since_next;
    logic           w_match;
    logic [7:0]     w_count_next;
    logic           w_last_bit;

    assign w_tick_end    = (r_tick == TICK_LAST);

    // Index 0 means word bit 15, so the word bit to send is 15 - index, which
    // for a 4-bit index is simply its bitwise inverse.
    assign w_next_bit    = r_word[~r_bit_index];

    assign w_window_next = {r_window[2:0], w_next_bit};

    // since_match counts bits emitted since the last counted match, saturating
    // at 4. A match needs all four window bits to be fresh, which is what
    // prevents overlapping occurrences from being counted twice.
    assign w_since_next  = (r_since_match == 3'd4) ? 3'd4 : (r_since_match + 3'd1);
    assign w_match       = (w_window_next == PATTERN) && (w_since_next == 3'd4);
    assign w_count_next  = (w_match && (r_count != 8'hFF)) ? (r_count + 8'd1) : r_count;

    assign w_last_bit    = (r_bit_index == 4'd15);

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_word        <= 16'h0000;
            r_tick        <= '0;
            r_window      <= 4'd0;
            r_since_match <= 3'd0;
            r_repeat      <= 1'b0;
            r_bit_out     <= 1'b0;
            r_bit_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_bit_index   <= 4'd0;
            r_count       <= 8'd0;
        end else begin
            // The strobe is a single-cycle pulse; only the emit branch raises it.
            r_bit_valid <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        // load wins over a simultaneous start
                        r_word        <= load_data;
                        r_count       <= 8'd0;
                        r_bit_index   <= 4'd0;
                        r_window      <= 4'd0;
                        r_since_match <= 3'd0;
                        r_bit_out     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else if (start) begin
                        r_repeat      <= repeat_en;
                        r_tick        <= '0;
                        r_count       <= 8'd0;
                        r_bit_index   <= 4'd0;
                        r_window      <= 4'd0;
                        r_since_match <= 3'd0;
                        r_bit_out     <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_state       <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        // Count and index freeze; a strobe due this edge is dropped.
                        r_tick  <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_tick_end) begin
                        r_tick        <= '0;
                        r_bit_out     <= w_next_bit;
                        r_bit_valid   <= 1'b1;
                        r_bit_index   <= r_bit_index + 4'd1;
                        r_window      <= w_window_next;
                        r_since_match <= w_match ? 3'd0 : w_since_next;
                        r_count       <= w_count_next;
                        // In repeat mode the window and since_match carry over
                        // the wrap, so a match may straddle two passes.
                        if (w_last_bit && !r_repeat) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_tick <= r_tick + CW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_out        = r_bit_out;
    assign bit_valid      = r_bit_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign bit_index      = r_bit_index;
    assign expected_count = r_count;

endmodule

// File: doc/pattern_stream_generator.md
# pattern_stream_generator

Transmit-side counterpart of the board's serial pattern-detector path. It takes a 16-bit stimulus word from a parallel load port and emits it MSB-first, one bit per step period, with a one-cycle valid strobe. It feeds the detector's `bit` input in place of the fixed 16x1 block-RAM stimulus. Alongside the stream it keeps a golden non-overlapping match count for a 4-bit target pattern, so the detector's `pattern_count` can be compared live on the VIO/display.

## Interface
- `TICK_DIV`, 100000000: clock cycles per emitted bit (1 s at 100 MHz); legal values are ≥ 2. Benches use 4.
- `PATTERN`, 4'b1011: target pattern, compared MSB = oldest bit.
- `clock_100Mhz` in 1: the single clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-low; asserted while 0.
- `load` in 1: capture `load_data`; honoured only when not busy.
- `load_data` in 16: stimulus word; bit 15 is sent first.
- `start` in 1: begin streaming; honoured in IDLE or DONE.
- `repeat_en` in 1: sampled with `start`; 1 means wrap from bit 0 to bit 15 indefinitely.
- `abort` in 1: stop streaming and return to IDLE.
- `bit_out` out 1: current stream bit; holds its value between strobes.
- `bit_valid` out 1: one-cycle strobe marking a new `bit_out`.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `bit_index` out 4: index of the next bit to send (0 = word bit 15).
- `expected_count` out 8: golden non-overlapping match count; saturates at 255.

## Operation
- **FSM states.** IDLE, RUN, DONE.
- **Reset values.** Reset clears all outputs: `bit_out` = 0, `bit_valid` = 0, `busy` = 0, `done` = 0, `bit_index` = 0, `expected_count` = 0. It also clears the internal state: word = 16'h0000, tick counter = 0, match window = 0, `since_match` = 0, state = IDLE.
- **Load.** In IDLE or DONE, `load` = 1 writes the word, clears `expected_count`, `bit_index` and the match state, and moves the FSM to IDLE. `load` during RUN is ignored.
- **Start.** In IDLE or DONE, `start` = 1 (without `load`) moves to RUN, latches `repeat_en`, and zeroes the tick counter, `bit_index`, `expected_count` and the match state. If `load` and `start` arrive in the same cycle, `load` wins and `start` is dropped.
- **RUN, tick counting.** The tick counter counts 0 .. TICK_DIV-1 and wraps.
- **RUN, emitting a bit.** On the edge where the counter equals TICK_DIV-1, the block does all of the following on that same edge:
  - `bit_out` <= word[15 - `bit_index`], and `bit_valid` <= 1 for exactly one cycle.
  - `bit_index` increments, wrapping 15 -> 0.
  - The 4-bit window shifts in the new bit.
- **Golden match rule.** `since_match` is a 3-bit counter that saturates at 4 and increments with each emitted bit. A match is counted when the window after the shift equals PATTERN and `since_match` (including the new bit) is ≥ 4. A match increments `expected_count` (saturating at 255) and clears `since_match` to 0. This gives greedy, non-overlapping counting.
- **End of word.** After bit index 15 is emitted:
  - `repeat_en` latched 0: go to DONE; `bit_index` reads 0.
  - `repeat_en` latched 1: stay in RUN. The window and `since_match` carry across the wrap, so matches can span pass boundaries.
- **DONE.** `done` = 1 and `bit_out` holds the last bit until the next `start` or `load`.
- **Abort.** `abort` in RUN goes to IDLE on the next edge. `bit_valid` is forced 0 that cycle, even if the counter is at TICK_DIV-1. `expected_count` and `bit_index` freeze at their values. `abort` outside RUN has no effect.
- **Reset mid-RUN.** Everything returns to reset values immediately; the loaded word is lost.

## Timing
- Let E0 be the edge that enters RUN. Bit k is first presented on edge E0 + (k+1)·TICK_DIV and `bit_valid` is high for the cycle after that edge.
- `expected_count` updates on the same edge as `bit_valid`, so it is coherent with the bit being strobed.
- The DONE transition happens on the edge that emits bit 15. `busy` falls and `done` rises in the same cycle that `bit_valid` is high.
- Start-to-first-valid latency is TICK_DIV + 1 cycles, counted from the cycle in which `start` is sampled.
- There is no combinational path from any input to any output.

## Test plan
- **Reset.** Assert `reset` = 0 mid-RUN -> all outputs 0 within the same cycle (asynchronous). Release reset, then `start` -> 16 bits of 0 are emitted and `expected_count` = 0.
- **Basic stream.** TICK_DIV = 4, load 16'hB6DB, start with `repeat_en` = 0 -> bit sequence 1011011011011011 with `bit_valid` every 4 cycles; `expected_count` steps to 1, 2, 3 at bits 3, 9, 15 (overlapping counting would give 5); `done` = 1 after 64 cycles.
- **No-match word.** Load 16'hFFFF and run -> `expected_count` = 0 and `done` = 1.
- **Repeat with wrap.** Load 16'hB6DB, `repeat_en` = 1 -> after 32 strobes `expected_count` = 6 and `busy` is still 1. Then pulse `abort` exactly on a strobe edge -> no `bit_valid`, state IDLE, count frozen at 6.
- **Load/start collisions.** `load` during RUN -> ignored and the stream continues unchanged. Simultaneous `load` + `start` in IDLE -> word updated, FSM stays in IDLE, `busy` = 0.
- **Saturation.** Load 16'hBBBB (4 matches per pass) with repeat -> `expected_count` climbs to 255 and holds at 255; it never wraps to 0.
